// File: rtl/vector_issue_scheduler_pkg.sv
// Shared types and functional-unit tables for the vector issue scheduler.
// Tag order matches vector_execution.
package vector_issue_scheduler_pkg;

  localparam int FU_COUNT = 21;
  localparam int FU_MAX_LATENCY = 16;
  localparam int FU_TAG_WIDTH = 5;
  localparam int TAG_WIDTH = 5;

  typedef logic [4:0] latency_t;

  typedef struct packed {
    logic [FU_TAG_WIDTH-1:0] functional_unit_tag;
    logic [7:0]              operation;
    logic [TAG_WIDTH-1:0]    vs1;
    logic [TAG_WIDTH-1:0]    vs2;
    logic [TAG_WIDTH-1:0]    vd;
  } execution_packet_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
  } reservation_entry_t;

  localparam latency_t FUNCTIONAL_UNIT_LATENCY [FU_COUNT] = '{
    5'd1, 5'd1, 5'd16, 5'd1, 5'd1, 5'd1, 5'd1,
    5'd3, 5'd4, 5'd1, 5'd1, 5'd2, 5'd3, 5'd1,
    5'd16, 5'd1, 5'd1, 5'd5, 5'd4, 5'd1, 5'd16
  };

  // Divide, fp divide and square root are iterative.
  localparam logic [FU_COUNT-1:0] FUNCTIONAL_UNIT_PIPELINED =
    21'b0_11111_0_11111111111_0_11;

  localparam logic [FU_TAG_WIDTH-1:0] FU_LIMIT =
    FU_TAG_WIDTH'(FU_COUNT);

  function automatic latency_t unit_latency(
    input logic [FU_TAG_WIDTH-1:0] fu
  );
    if (fu < FU_LIMIT) return FUNCTIONAL_UNIT_LATENCY[fu];
    return 5'd1;
  endfunction

  function automatic logic unit_pipelined(
    input logic [FU_TAG_WIDTH-1:0] fu
  );
    if (fu < FU_LIMIT) return FUNCTIONAL_UNIT_PIPELINED[fu];
    return 1'b1;
  endfunction

endpackage

// File: rtl/vector_issue_scheduler_issue_fifo.sv
// Synchronous FIFO with flush; no bypass, pushes and pops gated by
// registered full/empty only.
module issue_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clock,
  input  logic reset_n,
  input  logic flush,
  input  logic push,
  input  T     data_in,
  input  logic pop,
  output T     data_out,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);

  T mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign push_ok  = push && !full && !flush;
  assign pop_ok   = pop && !empty && !flush;
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/vector_issue_scheduler.sv
// In-order issue control: holds the head packet until its unit is free
// and its writeback slot on the shared bus is unclaimed.
module vector_issue_scheduler
  import vector_issue_scheduler_pkg::*;
#(
  parameter int QUEUE_DEPTH             = 4,
  parameter int MAX_LATENCY             = FU_MAX_LATENCY,
  parameter int NUMBER_FUNCTIONAL_UNITS = FU_COUNT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  execution_packet_t    input_packet,
  input  logic                 flush,
  output logic                 issue_valid,
  output execution_packet_t    issue_packet,
  output logic                 writeback_valid,
  output logic [TAG_WIDTH-1:0] writeback_tag,
  output logic                 illegal_unit_error
);

  localparam int SW = $clog2(MAX_LATENCY);

  execution_packet_t       head;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    can_issue;
  logic                    legal;
  logic                    pipelined;
  logic [FU_TAG_WIDTH-1:0] fu;
  logic [SW:0]             lat;
  logic [SW-1:0]           lat_m1;
  logic                    error_q;

  reservation_entry_t slot [MAX_LATENCY];
  logic [SW-1:0]      busy [NUMBER_FUNCTIONAL_UNITS];

  issue_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .T     (execution_packet_t)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .push     (input_valid),
    .data_in  (input_packet),
    .pop      (can_issue),
    .data_out (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
    fu        = head.functional_unit_tag;
    legal     = int'(fu) < NUMBER_FUNCTIONAL_UNITS;
    lat       = legal ? (SW+1)'(unit_latency(fu)) : (SW+1)'(1);
    pipelined = legal ? unit_pipelined(fu) : 1'b1;
    lat_m1    = SW'(lat - 1'b1);
    can_issue = !fifo_empty && !flush;
    // A result landing in slot L-1 next edge collides with whatever
    // currently sits in slot L.
    if (lat < (SW+1)'(MAX_LATENCY) && slot[lat[SW-1:0]].valid)
      can_issue = 1'b0;
    if (!pipelined && busy[fu] != '0)
      can_issue = 1'b0;
  end

  assign input_ready        = !fifo_full;
  assign issue_valid        = can_issue;
  assign issue_packet       = can_issue ? head : '0;
  assign writeback_valid    = slot[0].valid;
  assign writeback_tag      = slot[0].valid ? slot[0].tag : '0;
  assign illegal_unit_error = error_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_LATENCY; i++) slot[i] <= '0;
      error_q <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_LATENCY-1; i++) slot[i] <= slot[i+1];
      slot[MAX_LATENCY-1] <= '0;
      if (can_issue) begin
        slot[lat_m1] <= '{valid: 1'b1, tag: head.vd};
        if (!legal) error_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUMBER_FUNCTIONAL_UNITS; i++) busy[i] <= '0;
    end else begin
      for (int i = 0; i < NUMBER_FUNCTIONAL_UNITS; i++) begin
        if (can_issue && !pipelined && int'(fu) == i)
          busy[i] <= lat_m1;
        else if (busy[i] != '0)
          busy[i] <= busy[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vector_issue_scheduler.sv
// Bench for vector_issue_scheduler: directed scenarios and random traffic
// against a time-stamped reference model.
module tb_vector_issue_scheduler;
  import vector_issue_scheduler_pkg::*;

  logic              clock;
  logic              reset_n;
  logic              input_valid;
  logic              input_ready;
  execution_packet_t input_packet;
  logic              flush;
  logic              issue_valid;
  execution_packet_t issue_packet;
  logic              writeback_valid;
  logic [4:0]        writeback_tag;
  logic              illegal_unit_error;

  vector_issue_scheduler dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .input_valid        (input_valid),
    .input_ready        (input_ready),
    .input_packet       (input_packet),
    .flush              (flush),
    .issue_valid        (issue_valid),
    .issue_packet       (issue_packet),
    .writeback_valid    (writeback_valid),
    .writeback_tag      (writeback_tag),
    .illegal_unit_error (illegal_unit_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  int lat_tab [21] = '{1, 1, 16, 1, 1, 1, 1, 3, 4, 1, 1,
                       2, 3, 1, 16, 1, 1, 5, 4, 1, 16};

  // Model state: absolute cycle number, queued packets, writeback
  // calendar keyed by cycle, and cycle at which each iterative unit frees.
  int                now;
  execution_packet_t mq [$];
  bit                wbv [64];
  logic [4:0]        wbt [64];
  int                free_at [32];
  bit                merr;

  bit                e_ready, e_iv, e_wbv, e_err;
  execution_packet_t e_pkt;
  logic [4:0]        e_wbt;

  function automatic int m_lat(int fu);
    return (fu < 21) ? lat_tab[fu] : 1;
  endfunction

  function automatic bit m_pipe(int fu);
    return !(fu == 2 || fu == 14 || fu == 20);
  endfunction

  function automatic void m_clear();
    mq.delete();
    for (int i = 0; i < 64; i++) begin wbv[i] = 0; wbt[i] = '0; end
    for (int i = 0; i < 32; i++) free_at[i] = 0;
    merr = 0;
  endfunction

  function automatic void m_predict();
    int fu, l;
    e_ready = mq.size() < 4;
    e_iv = 0;
    if (mq.size() > 0 && !flush) begin
      fu = int'(mq[0].functional_unit_tag);
      l  = m_lat(fu);
      e_iv = !wbv[(now + l) % 64] && (m_pipe(fu) || now >= free_at[fu]);
    end
    e_pkt = e_iv ? mq[0] : '0;
    e_wbv = wbv[now % 64];
    e_wbt = e_wbv ? wbt[now % 64] : 5'd0;
    e_err = merr;
  endfunction

  function automatic void m_advance();
    execution_packet_t p;
    int fu, l;
    if (!reset_n) begin
      m_clear();
    end else begin
      wbv[now % 64] = 0;
      if (e_iv) begin
        p  = mq.pop_front();
        fu = int'(p.functional_unit_tag);
        l  = m_lat(fu);
        wbv[(now + l) % 64] = 1;
        wbt[(now + l) % 64] = p.vd;
        if (!m_pipe(fu)) free_at[fu] = now + l;
        if (fu >= 21) merr = 1;
      end
      if (flush) mq.delete();
      else if (input_valid && e_ready) mq.push_back(input_packet);
    end
    now++;
  endfunction

  function automatic logic [36:0] dut_vec();
    return {input_ready, issue_valid, issue_packet,
            writeback_valid, writeback_tag, illegal_unit_error};
  endfunction

  function automatic logic [36:0] exp_vec();
    return {e_ready, e_iv, e_pkt, e_wbv, e_wbt, e_err};
  endfunction

  function automatic execution_packet_t mk(int fu, int vd);
    execution_packet_t p;
    p.functional_unit_tag = 5'(fu);
    p.operation = 8'($urandom);
    p.vs1 = 5'($urandom);
    p.vs2 = 5'($urandom);
    p.vd  = 5'(vd);
    return p;
  endfunction

  task automatic drive(input bit v, input execution_packet_t p,
                       input bit f, input bit rn);
    input_valid  = v;
    input_packet = p;
    flush        = f;
    reset_n      = rn;
    #1;
    m_predict();
  endtask

  task automatic finish_cycle();
    m_advance();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; input_valid = 1'b0; flush = 1'b0; input_packet = '0;
    @(negedge clock);
    m_clear();
    now = 0;
    for (int c = 0; c < 6; c++) begin
      drive(0, '0, 0, c >= 3);
      total++;
      if ({input_ready, issue_valid, issue_packet, writeback_valid,
           writeback_tag, illegal_unit_error} !== {1'b1, 36'd0}) begin
        $display("FAIL reset_idle cycle %0d got %h expected %h",
                 c, dut_vec(), {1'b1, 36'd0});
      end else passed++;
      finish_cycle();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 8; c++) begin
      drive(c < 3, mk(4, 5 + c), 0, 1);
      total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL back_to_back cycle %0d got %h expected %h",
                 c, dut_vec(), exp_vec());
      else passed++;
      finish_cycle();
    end
  endtask

  task automatic test_collision();
    for (int c = 0; c < 10; c++) begin
      if (c == 0)      drive(1, mk(7, 3), 0, 1);
      else if (c == 1) drive(1, mk(4, 9), 0, 1);
      else             drive(0, '0, 0, 1);
      total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL collision cycle %0d got %h expected %h",
                 c, dut_vec(), exp_vec());
      else passed++;
      finish_cycle();
    end
  endtask

  task automatic test_division();
    for (int c = 0; c < 40; c++) begin
      drive(c < 2, mk(2, 20 + c), 0, 1);
      total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL division cycle %0d got %h expected %h",
                 c, dut_vec(), exp_vec());
      else passed++;
      finish_cycle();
    end
  endtask

  task automatic test_full_flush();
    for (int c = 0; c < 24; c++) begin
      drive(c < 7, mk(2, 1 + c), c == 6, 1);
      total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL full_flush cycle %0d got %h expected %h",
                 c, dut_vec(), exp_vec());
      else passed++;
      if (c == 5 || c == 7) begin
        total++;
        if (input_ready !== (c == 7))
          $display("FAIL full_flush_ready cycle %0d got %b expected %b",
                   c, input_ready, c == 7);
        else passed++;
      end
      finish_cycle();
    end
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 16; c++) begin
      if (c == 0)       drive(1, mk(8, 12), 0, 1);
      else if (c == 11) drive(1, mk(25, 11), 0, 1);
      else              drive(0, '0, 0, c != 3);
      total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL reset_midflight cycle %0d got %h expected %h",
                 c, dut_vec(), exp_vec());
      else passed++;
      if (c >= 4 && c <= 10) begin
        total++;
        if (writeback_valid !== 1'b0)
          $display("FAIL dropped_writeback cycle %0d got %b expected 0",
                   c, writeback_valid);
        else passed++;
      end
      if (c == 14) begin
        total++;
        if (illegal_unit_error !== 1'b1)
          $display("FAIL illegal_sticky got %b expected 1",
                   illegal_unit_error);
        else passed++;
      end
      finish_cycle();
    end
  endtask

  task automatic test_random();
    int fu;
    for (int c = 0; c < 600; c++) begin
      fu = ($urandom_range(0, 39) == 0) ? int'($urandom_range(21, 31))
                                        : int'($urandom_range(0, 20));
      drive($urandom_range(0, 3) != 0, mk(fu, int'($urandom_range(0, 31))),
            $urandom_range(0, 24) == 0, $urandom_range(0, 149) != 0);
      total++;
      if (dut_vec() !== exp_vec())
        $display("FAIL random cycle %0d got %h expected %h",
                 c, dut_vec(), exp_vec());
      else passed++;
      finish_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_collision();
    test_division();
    test_full_flush();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
